// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port round-robin memory arbiter; optional watchdog via MEMORY_ARBITER_TIMEOUT_EN
module memory_arbiter #(
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              p0_read_req,
    input  logic              p0_write_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_read_req,
    input  logic              p1_write_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_busy,
    output logic              arb_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              lat_port;
    logic              lat_write;
    logic              p0_pend;
    logic              p1_pend;
    logic              grant;
    logic              grant_port;
    logic              rdata_load;
    logic              timeout_hit;
    logic [DATA_W-1:0] rdata_cap;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign p0_pend = p0_read_req | p0_write_req;
    assign p1_pend = p1_read_req | p1_write_req;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        rdata_load = 1'b0;
        case (state)
            IDLE: begin
                if (p0_pend || p1_pend) begin
                    grant      = 1'b1;
                    // Tie goes to the port that did not win last time.
                    grant_port = (p0_pend && p1_pend) ? ~last_grant : p1_pend;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (!mem_busy || timeout_hit) begin
                    state_next = DONE;
                    rdata_load = ~lat_write;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_busy can only still be high here on a watchdog abort, which returns zero.
    assign rdata_cap = mem_busy ? '0 : mem_data_i;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_write  <= 1'b0;
            mem_addr   <= '0;
            mem_data_o <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                last_grant <= grant_port;
                lat_port   <= grant_port;
                lat_write  <= grant_port ? p1_write_req : p0_write_req;
                mem_addr   <= grant_port ? p1_addr : p0_addr;
                mem_data_o <= grant_port ? p1_wdata : p0_wdata;
            end
            if (rdata_load) begin
                if (lat_port) begin
                    p1_rdata <= rdata_cap;
                end else begin
                    p0_rdata <= rdata_cap;
                end
            end
        end
    end

    assign mem_read_req  = (state == ISSUE) && !lat_write;
    assign mem_write_req = (state == ISSUE) && lat_write;
    assign p0_ack        = (state == DONE) && !lat_port;
    assign p1_ack        = (state == DONE) && lat_port;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;
    logic       timed_out;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wd_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (grant) begin
            wd_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state == WAIT && mem_busy) begin
            if (timeout_hit) begin
                timed_out <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    assign timeout_hit = (state == WAIT) && mem_busy && (wd_cnt == TO_LAST);
    assign arb_timeout = (state == DONE) && timed_out;
`else
    assign timeout_hit = 1'b0;
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              sys_clk = 1'b0;
    logic              reset = 1'b1;
    logic              p0_read_req = 1'b0;
    logic              p0_write_req = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ack;
    logic              p1_read_req = 1'b0;
    logic              p1_write_req = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ack;
    logic              mem_read_req;
    logic              mem_write_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_busy = 1'b0;
    logic              arb_timeout;

    logic [DATA_W-1:0] mem_model [16];
    int checks = 0;
    int errors = 0;
    int inv_err = 0;

    memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(255)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_addr(mem_addr),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_busy(mem_busy),
        .arb_timeout(arb_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Word memory: word i holds A000_000i, word 4 holds 1234_5678.
    always @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_model[i] <= 32'hA000_0000 + i;
            mem_model[4] <= 32'h1234_5678;
        end else if (mem_write_req) begin
            mem_model[mem_addr[5:2]] <= mem_data_o;
        end
    end

    assign mem_data_i = mem_busy ? 32'hDEAD_BEEF : mem_model[mem_addr[5:2]];

    always @(negedge sys_clk) begin
        if (p0_ack && p1_ack) inv_err++;
        if (mem_read_req && mem_write_req) inv_err++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({p0_ack, p1_ack, mem_read_req, mem_write_req, arb_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {p0_ack, p1_ack, mem_read_req, mem_write_req, arb_timeout});
        end
        checks++;
        if (mem_addr !== '0 || mem_data_o !== '0) begin
            errors++;
            $display("FAIL reset_mem: got addr %h data %h expected 0 0", mem_addr, mem_data_o);
        end
        checks++;
        if (p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h expected 0 0", p0_rdata, p1_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        p0_addr = 17'h00010;
        p0_read_req = 1'b1;
        tick();
        checks++;
        if (mem_read_req !== 1'b1 || mem_addr !== 17'h00010 || p0_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: got rd %b addr %h ack %b expected 1 00010 0", mem_read_req, mem_addr, p0_ack);
        end
        tick();
        checks++;
        if (mem_read_req !== 1'b0 || p0_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: got rd %b ack %b expected 0 0", mem_read_req, p0_ack);
        end
        tick();
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_ack: got ack %b rdata %h expected 1 12345678", p0_ack, p0_rdata);
        end
        p0_read_req = 1'b0;
        tick();
        checks++;
        if (p0_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_pulse: got %b expected 0", p0_ack);
        end
    endtask

    task automatic test_both_after_reset();
        int a0 = -1;
        int a1 = -1;
        reset = 1'b1;
        p0_addr = 17'h4;
        p0_read_req = 1'b1;
        p1_addr = 17'h8;
        p1_wdata = 32'hCAFE_F00D;
        p1_write_req = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (p0_ack && a0 < 0) begin a0 = c; p0_read_req = 1'b0; end
            if (p1_ack && a1 < 0) begin a1 = c; p1_write_req = 1'b0; end
        end
        checks++;
        if (a0 != 3 || a1 != 7) begin
            errors++;
            $display("FAIL both_ack_cycles: got p0 %0d p1 %0d expected 3 7", a0, a1);
        end
        checks++;
        if (mem_model[2] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL both_mem_write: got %h expected cafef00d", mem_model[2]);
        end
        checks++;
        if (p0_rdata !== 32'hA000_0001 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL both_rdata: got %h %h expected a0000001 00000000", p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int order [6];
        int acyc [6];
        p0_addr = 17'h0C;
        p1_addr = 17'h14;
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ((p0_ack || p1_ack) && n < 6) begin
                order[n] = p1_ack ? 1 : 0;
                acyc[n] = c;
                checks++;
                if (p1_ack ? (p1_rdata !== 32'hA000_0005) : (p0_rdata !== 32'hA000_0003)) begin
                    errors++;
                    $display("FAIL rr_rdata[%0d]: got %h / %h expected a0000003 / a0000005", n, p0_rdata, p1_rdata);
                end
                n++;
                if (n == 6) begin
                    p0_read_req = 1'b0;
                    p1_read_req = 1'b0;
                end
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL rr_count: got %0d acks expected 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != (i % 2) || acyc[i] != 3 + 4 * i) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got port %0d cycle %0d expected port %0d cycle %0d", i, order[i], acyc[i], i % 2, 3 + 4 * i);
            end
        end
    endtask

    task automatic test_write_priority();
        int ack = -1;
        bit saw_wr = 1'b0;
        bit saw_rd = 1'b0;
        p0_addr = 17'h18;
        p0_wdata = 32'h5555_AAAA;
        p0_read_req = 1'b1;
        p0_write_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_write_req) saw_wr = 1'b1;
            if (mem_read_req) saw_rd = 1'b1;
            if (p0_ack && ack < 0) begin
                ack = c;
                p0_read_req = 1'b0;
                p0_write_req = 1'b0;
            end
        end
        checks++;
        if (ack != 3 || saw_wr !== 1'b1 || saw_rd !== 1'b0) begin
            errors++;
            $display("FAIL wr_prio_op: got ack %0d wr %b rd %b expected 3 1 0", ack, saw_wr, saw_rd);
        end
        checks++;
        if (mem_model[6] !== 32'h5555_AAAA || p0_rdata !== 32'hA000_0003) begin
            errors++;
            $display("FAIL wr_prio_data: got mem %h rdata %h expected 5555aaaa a0000003", mem_model[6], p0_rdata);
        end
    endtask

    task automatic test_busy();
        int ack = -1;
        p1_addr = 17'h1C;
        p1_read_req = 1'b1;
        mem_busy = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (mem_read_req !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_issue: got %b expected 1", mem_read_req);
                end
            end
            if (p1_ack && ack < 0) begin ack = c; p1_read_req = 1'b0; end
            if (c == 7) mem_busy = 1'b0;
        end
        checks++;
        if (ack != 8 || p1_rdata !== 32'hA000_0007) begin
            errors++;
            $display("FAIL busy_ack: got cycle %0d rdata %h expected 8 a0000007", ack, p1_rdata);
        end
        checks++;
        if (p0_rdata !== 32'hA000_0003) begin
            errors++;
            $display("FAIL busy_other_rdata: got %h expected a0000003", p0_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int ack = -1;
        p0_addr = 17'h10;
        p0_read_req = 1'b1;
        mem_busy = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        p0_read_req = 1'b0;
        mem_busy = 1'b0;
        tick();
        if (p0_ack || p1_ack) acks++;
        tick();
        if (p0_ack || p1_ack) acks++;
        checks++;
        if ({p0_ack, p1_ack, mem_read_req, mem_write_req, arb_timeout} !== 5'b0 ||
            mem_addr !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctl %b addr %h rdata %h %h expected all 0",
                     {p0_ack, p1_ack, mem_read_req, mem_write_req, arb_timeout}, mem_addr, p0_rdata, p1_rdata);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (p0_ack || p1_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midrst_no_ack: got %0d acks expected 0", acks);
        end
        p0_read_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (p0_ack && ack < 0) begin ack = c; p0_read_req = 1'b0; end
        end
        checks++;
        if (ack != 3 || p0_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midrst_next: got cycle %0d rdata %h expected 3 12345678", ack, p0_rdata);
        end
    endtask

    task automatic test_timeout();
        p0_addr = 17'h10;
        p0_read_req = 1'b1;
        mem_busy = 1'b1;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        begin
            int ack = -1;
            logic to_at_ack = 1'b0;
            for (int c = 1; c <= 400; c++) begin
                tick();
                if (p0_ack && ack < 0) begin
                    ack = c;
                    to_at_ack = arb_timeout;
                    p0_read_req = 1'b0;
                    checks++;
                    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
                        errors++;
                        $display("FAIL timeout_rdata: got %h %h expected 0 0", p0_rdata, p1_rdata);
                    end
                end else if (ack > 0 && c == ack + 1) begin
                    checks++;
                    if (arb_timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_pulse: got %b expected 0", arb_timeout);
                    end
                end
            end
            checks++;
            if (ack != 257 || to_at_ack !== 1'b1) begin
                errors++;
                $display("FAIL timeout_ack: got cycle %0d timeout %b expected 257 1", ack, to_at_ack);
            end
        end
`else
        begin
            int acks = 0;
            int tos = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (p0_ack || p1_ack) acks++;
                if (arb_timeout) tos++;
            end
            checks++;
            if (acks != 0 || tos != 0) begin
                errors++;
                $display("FAIL no_timeout: got %0d acks %0d timeouts expected 0 0", acks, tos);
            end
        end
`endif
        p0_read_req = 1'b0;
        mem_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_both_after_reset();
        test_round_robin();
        test_write_priority();
        test_busy();
        test_reset_mid();
        test_timeout();
        checks++;
        if (inv_err != 0) begin
            errors++;
            $display("FAIL exclusivity: got %0d violations expected 0", inv_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
